axi_lite_mem_slave: RTL and testbench

Parametrised AXI4-Lite memory slave, the next generation of the team's single-width 4 KB slave. Width, depth and base address are generic. AW and W are accepted independently, in either order or together. The write and read paths run concurrently. Addresses outside the decoded window get SLVERR instead of aliasing. It sits behind the interconnect as a scratchpad or register-file target.

---
 rtl/axi_lite_pkg.sv | 31 +++
 rtl/axi_lite_mem_array.sv | 53 +++++
 rtl/axi_lite_mem_slave.sv | 182 ++++++++++++++++++
 tb/tb_axi_lite_mem_slave.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared response codes, FSM encodings and helpers for the AXI-Lite memory slave
//
// Purpose : common definitions imported by axi_lite_mem_slave and axi_lite_mem_array.
// Contents: RESP_OKAY / RESP_SLVERR response codes, write/read FSM state
//           encodings, clog2 helper for elaboration-time sizing.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      W_ACCEPT = 1'b0,
      W_RESP   = 1'b1
   } wr_state_t;

   typedef enum logic {
      R_ADDR = 1'b0,
      R_DATA = 1'b1
   } rd_state_t;

   // Ceiling log2, used only for sizing at elaboration time.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/axi_lite_mem_array.sv
// rtl/axi_lite_mem_array.sv - word-wide storage with one byte-enabled write port and one registered read port
//
// Purpose : backing store for axi_lite_mem_slave.
// Ports   : clk, rst_n       clock, asynchronous active-low reset (read register only)
//           wr_en            commit wr_data into word wr_addr, lanes selected by wr_strb
//           wr_addr/wr_data/wr_strb  write word index, data, byte enables
//           rd_en            sample word rd_addr into rd_data on this edge
//           rd_addr          read word index
//           rd_data          registered read data, held until the next rd_en
module axi_lite_mem_array
   import axi_lite_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 1024
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wr_en,
   input  logic [clog2(MEM_DEPTH)-1:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0]         wr_data,
   input  logic [DATA_WIDTH/8-1:0]       wr_strb,
   input  logic                          rd_en,
   input  logic [clog2(MEM_DEPTH)-1:0]   rd_addr,
   output logic [DATA_WIDTH-1:0]         rd_data
);

   localparam int BYTES = DATA_WIDTH / 8;

   // Contents are not reset; the declaration initialiser gives a known
   // all-zero image in simulation and on targets that support init values.
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH] = '{default: '0};

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < BYTES; b++) begin
            if (wr_strb[b]) begin
               mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
         end
      end
   end

   // Separate process from the write: a read and a write of the same word on
   // the same edge both use the pre-edge contents, so the read sees old data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/axi_lite_mem_slave.sv
// rtl/axi_lite_mem_slave.sv - parametrised AXI4-Lite memory slave with SLVERR outside its window
//
// Purpose : AXI4-Lite scratchpad / register-file target. AW and W are accepted
//           independently; write and read paths run concurrently.
// Ports   : clk, rst_n                          clock, asynchronous active-low reset
//           awaddr/awvalid/awready              write address channel
//           wdata/wstrb/wvalid/wready           write data channel
//           bresp/bvalid/bready                 write response channel
//           araddr/arvalid/arready              read address channel
//           rdata/rresp/rvalid/rready           read data channel
module axi_lite_mem_slave
   import axi_lite_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    MEM_DEPTH  = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [ADDR_WIDTH-1:0]     awaddr,
   input  logic                      awvalid,
   output logic                      awready,
   input  logic [DATA_WIDTH-1:0]     wdata,
   input  logic [DATA_WIDTH/8-1:0]   wstrb,
   input  logic                      wvalid,
   output logic                      wready,
   output logic [1:0]                bresp,
   output logic                      bvalid,
   input  logic                      bready,
   input  logic [ADDR_WIDTH-1:0]     araddr,
   input  logic                      arvalid,
   output logic                      arready,
   output logic [DATA_WIDTH-1:0]     rdata,
   output logic [1:0]                rresp,
   output logic                      rvalid,
   input  logic                      rready
);

   localparam int BYTES    = DATA_WIDTH / 8;
   localparam int ADDR_LSB = clog2(BYTES);
   localparam int IDX_W    = clog2(MEM_DEPTH);

   // Offsets carry one extra bit: an address below BASE_ADDR borrows into it,
   // which makes the offset exceed SPAN and so fails the single range compare.
   localparam logic [ADDR_WIDTH:0] BASE_EXT = {1'b0, BASE_ADDR};
   localparam logic [ADDR_WIDTH:0] SPAN     = (ADDR_WIDTH + 1)'(MEM_DEPTH * BYTES);

   // ---------------- write path ----------------
   wr_state_t               wstate;
   logic                    aw_got;
   logic                    w_got;
   logic [ADDR_WIDTH-1:0]   awaddr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [BYTES-1:0]        wstrb_q;

   logic                    aw_hs;
   logic                    w_hs;
   logic [ADDR_WIDTH:0]     aw_offset;
   logic                    aw_in_range;
   logic                    wr_en;

   assign aw_hs       = awvalid && awready;
   assign w_hs        = wvalid && wready;
   assign aw_offset   = {1'b0, awaddr_q} - BASE_EXT;
   assign aw_in_range = aw_offset < SPAN;

   // Commit in the cycle after both halves are held; out-of-range writes
   // never reach the array so they cannot alias onto a real word.
   assign wr_en = (wstate == W_ACCEPT) && aw_got && w_got && aw_in_range;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wstate   <= W_ACCEPT;
         aw_got   <= 1'b0;
         w_got    <= 1'b0;
         awaddr_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         awready  <= 1'b0;
         wready   <= 1'b0;
         bvalid   <= 1'b0;
         bresp    <= RESP_OKAY;
      end else begin
         case (wstate)
            W_ACCEPT: begin
               if (aw_got && w_got) begin
                  bvalid  <= 1'b1;
                  bresp   <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
                  awready <= 1'b0;
                  wready  <= 1'b0;
                  wstate  <= W_RESP;
               end else begin
                  if (aw_hs) begin
                     awaddr_q <= awaddr;
                     aw_got   <= 1'b1;
                  end
                  if (w_hs) begin
                     wdata_q <= wdata;
                     wstrb_q <= wstrb;
                     w_got   <= 1'b1;
                  end
                  // Ready drops the edge a channel is captured and rises one
                  // edge after entering W_ACCEPT with nothing held.
                  awready <= !(aw_got || aw_hs);
                  wready  <= !(w_got || w_hs);
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid <= 1'b0;
                  aw_got <= 1'b0;
                  w_got  <= 1'b0;
                  wstate <= W_ACCEPT;
               end
            end
            default: wstate <= W_ACCEPT;
         endcase
      end
   end

   // ---------------- read path ----------------
   rd_state_t               rstate;
   logic                    ar_hs;
   logic [ADDR_WIDTH:0]     ar_offset;
   logic                    ar_in_range;
   logic [DATA_WIDTH-1:0]   mem_rd_data;

   assign ar_hs       = arvalid && arready;
   assign ar_offset   = {1'b0, araddr} - BASE_EXT;
   assign ar_in_range = ar_offset < SPAN;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rstate  <= R_ADDR;
         arready <= 1'b0;
         rvalid  <= 1'b0;
         rresp   <= RESP_OKAY;
      end else begin
         case (rstate)
            R_ADDR: begin
               if (ar_hs) begin
                  arready <= 1'b0;
                  rvalid  <= 1'b1;
                  rresp   <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
                  rstate  <= R_DATA;
               end else begin
                  arready <= 1'b1;
               end
            end
            R_DATA: begin
               if (rready) begin
                  rvalid <= 1'b0;
                  rstate <= R_ADDR;
               end
            end
            default: rstate <= R_ADDR;
         endcase
      end
   end

   // The array's read register only loads on in-range handshakes and holds
   // otherwise, so rdata stays stable under back-pressure; error reads are
   // forced to zero here rather than sampling an aliased word.
   assign rdata = (rresp == RESP_SLVERR) ? '0 : mem_rd_data;

   axi_lite_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH)
   ) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (aw_offset[ADDR_LSB +: IDX_W]),
      .wr_data (wdata_q),
      .wr_strb (wstrb_q),
      .rd_en   (ar_hs && ar_in_range),
      .rd_addr (ar_offset[ADDR_LSB +: IDX_W]),
      .rd_data (mem_rd_data)
   );

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// tb/tb_axi_lite_mem_slave.sv - self-checking bench for axi_lite_mem_slave against a word-array reference model
module tb_axi_lite_mem_slave;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] awaddr = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [31:0] araddr = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] model_mem [1024];

   always #5 clk = ~clk;

   axi_lite_mem_slave #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MEM_DEPTH  (1024),
      .BASE_ADDR  (32'h0)
   ) dut (
      .clk     (clk),     .rst_n   (rst_n),
      .awaddr  (awaddr),  .awvalid (awvalid), .awready (awready),
      .wdata   (wdata),   .wstrb   (wstrb),   .wvalid  (wvalid),  .wready (wready),
      .bresp   (bresp),   .bvalid  (bvalid),  .bready  (bready),
      .araddr  (araddr),  .arvalid (arvalid), .arready (arready),
      .rdata   (rdata),   .rresp   (rresp),   .rvalid  (rvalid),  .rready (rready)
   );

   // Reference model: 4 KB window at byte 0, 4-byte words, byte lanes by strobe.
   function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                              input logic [3:0] strb);
      if (addr >= 32'd4096) return 2'b10;
      for (int b = 0; b < 4; b++)
         if (strb[b]) model_mem[addr / 4][b*8 +: 8] = data[b*8 +: 8];
      return 2'b00;
   endfunction

   function automatic logic [31:0] model_rdata(input logic [31:0] addr);
      if (addr >= 32'd4096) return 32'h0;
      return model_mem[addr / 4];
   endfunction

   function automatic logic [1:0] model_rresp(input logic [31:0] addr);
      return (addr >= 32'd4096) ? 2'b10 : 2'b00;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(output bit ok);
      int c;
      c = 0;
      while (!(awready && wready && arready) && c < 20) begin
         tick();
         c++;
      end
      ok = awready && wready && arready;
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] resp, output bit ok);
      int  c;
      bit  aw_done, w_done, hs_aw, hs_w;
      ok = 1'b1; aw_done = 1'b0; w_done = 1'b0; c = 0;
      awaddr = addr; wdata = data; wstrb = strb;
      while (!(aw_done && w_done)) begin
         awvalid = !aw_done && (c >= aw_dly);
         wvalid  = !w_done && (c >= w_dly);
         hs_aw = awvalid && awready;
         hs_w  = wvalid && wready;
         tick();
         aw_done = aw_done || hs_aw;
         w_done  = w_done || hs_w;
         c++;
         if (c > 100) begin ok = 1'b0; break; end
      end
      awvalid = 1'b0; wvalid = 1'b0;
      c = 0;
      while (!bvalid && c < 50) begin tick(); c++; end
      if (!bvalid) ok = 1'b0;
      repeat (b_dly) tick();
      resp = bresp;
      bready = 1'b1;
      tick();
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, input int r_dly,
                           output logic [31:0] data, output logic [1:0] resp,
                           output bit lat1, output bit ok);
      int c;
      ok = 1'b1; c = 0;
      while (!arready && c < 50) begin tick(); c++; end
      if (!arready) ok = 1'b0;
      araddr = addr; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      lat1 = rvalid;
      c = 0;
      while (!rvalid && c < 50) begin tick(); c++; end
      if (!rvalid) ok = 1'b0;
      data = rdata; resp = rresp;
      repeat (r_dly) tick();
      rready = 1'b1;
      tick();
      rready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_checks++;
      if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs: got aw%b w%b ar%b b%b r%b bresp%h rresp%h rdata%h required all 0",
                  awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata);
      end
      rst_n = 1'b1;
      #1;
      n_checks++;
      if ({awready, wready, arready} !== 3'b000) begin
         n_errors++;
         $display("FAIL ready_before_edge: got %b required 000", {awready, wready, arready});
      end
      tick();
      n_checks++;
      if ({awready, wready, arready} !== 3'b111) begin
         n_errors++;
         $display("FAIL ready_after_edge: got %b required 111", {awready, wready, arready});
      end
   endtask

   task automatic test_same_cycle_write();
      bit ok, lat1;
      logic [31:0] d;
      logic [1:0]  r;
      wait_idle(ok);
      awaddr = 32'h010; wdata = 32'hDEADBEEF; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      n_checks++;
      if (bvalid !== 1'b0) begin
         n_errors++; $display("FAIL sc_bvalid_early: got %b required 0", bvalid);
      end
      tick();
      n_checks++;
      if ({bvalid, bresp} !== 3'b100) begin
         n_errors++; $display("FAIL sc_bresp: got bvalid=%b bresp=%b required 1/00", bvalid, bresp);
      end
      bready = 1'b1; tick(); bready = 1'b0;
      void'(model_write(32'h010, 32'hDEADBEEF, 4'hF));
      axi_read(32'h010, 0, d, r, lat1, ok);
      n_checks++;
      if (lat1 !== 1'b1 || ok !== 1'b1) begin
         n_errors++; $display("FAIL sc_read_latency: got lat1=%b ok=%b required 1/1", lat1, ok);
      end
      n_checks++;
      if (d !== 32'hDEADBEEF || r !== 2'b00) begin
         n_errors++; $display("FAIL sc_read_data: got %h/%b required deadbeef/00", d, r);
      end
   endtask

   task automatic test_w_before_aw();
      bit ok, lat1;
      logic [31:0] d;
      logic [1:0]  r;
      wait_idle(ok);
      wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      tick(); tick();
      n_checks++;
      if ({bvalid, awready, wready} !== 3'b010) begin
         n_errors++;
         $display("FAIL wfirst_waiting: got bvalid/awready/wready=%b required 010", {bvalid, awready, wready});
      end
      awaddr = 32'h020; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      n_checks++;
      if (bvalid !== 1'b0) begin
         n_errors++; $display("FAIL wfirst_bvalid_early: got %b required 0", bvalid);
      end
      tick();
      n_checks++;
      if ({bvalid, bresp} !== 3'b100) begin
         n_errors++; $display("FAIL wfirst_bresp: got %b/%b required 1/00", bvalid, bresp);
      end
      bready = 1'b1; tick(); bready = 1'b0;
      void'(model_write(32'h020, 32'h11223344, 4'hF));
      axi_write(32'h020, 32'hAABBCCDD, 4'h5, 0, 0, 0, r, ok);
      void'(model_write(32'h020, 32'hAABBCCDD, 4'h5));
      n_checks++;
      if (r !== 2'b00 || ok !== 1'b1) begin
         n_errors++; $display("FAIL strb_bresp: got %b ok=%b required 00 ok=1", r, ok);
      end
      axi_read(32'h020, 0, d, r, lat1, ok);
      n_checks++;
      if (d !== 32'h11BB33DD || d !== model_rdata(32'h020)) begin
         n_errors++; $display("FAIL strb_read: got %h required 11bb33dd", d);
      end
   endtask

   task automatic test_out_of_range();
      bit ok, lat1;
      logic [31:0] d;
      logic [1:0]  r;
      axi_write(32'h1000, 32'hCAFEF00D, 4'hF, 0, 0, 0, r, ok);
      n_checks++;
      if (r !== 2'b10 || ok !== 1'b1) begin
         n_errors++; $display("FAIL oor_bresp: got %b ok=%b required 10 ok=1", r, ok);
      end
      axi_read(32'h000, 0, d, r, lat1, ok);
      n_checks++;
      if (d !== model_rdata(32'h000)) begin
         n_errors++; $display("FAIL oor_no_alias: word0 got %h required %h", d, model_rdata(32'h000));
      end
      axi_read(32'h1000, 0, d, r, lat1, ok);
      n_checks++;
      if (d !== 32'h0 || r !== 2'b10) begin
         n_errors++; $display("FAIL oor_read: got %h/%b required 00000000/10", d, r);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int c;
      logic [1:0]  br;
      logic [31:0] rd;
      wait_idle(ok);
      awaddr = 32'h030; wdata = 32'h0BADCAFE; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      c = 0;
      while (!bvalid && c < 20) begin tick(); c++; end
      br = bresp;
      void'(model_write(32'h030, 32'h0BADCAFE, 4'hF));
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if ({bvalid, bresp, awready, wready} !== {1'b1, 2'b00, 2'b00} || bresp !== br) begin
            n_errors++;
            $display("FAIL b_stall[%0d]: got bvalid=%b bresp=%b awready=%b wready=%b required 1/00/0/0",
                     i, bvalid, bresp, awready, wready);
         end
         tick();
      end
      bready = 1'b1; tick(); bready = 1'b0;
      c = 0;
      while (!arready && c < 20) begin tick(); c++; end
      araddr = 32'h030; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      rd = rdata;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (rvalid !== 1'b1 || arready !== 1'b0 || rdata !== 32'h0BADCAFE || rdata !== rd) begin
            n_errors++;
            $display("FAIL r_stall[%0d]: got rvalid=%b arready=%b rdata=%h required 1/0/0badcafe",
                     i, rvalid, arready, rdata);
         end
         tick();
      end
      rready = 1'b1; tick(); rready = 1'b0;
   endtask

   task automatic test_collision();
      bit ok, lat1;
      logic [31:0] d;
      logic [1:0]  r;
      wait_idle(ok);
      awaddr = 32'h040; wdata = 32'h5; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      araddr = 32'h040; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      n_checks++;
      if ({bvalid, rvalid} !== 2'b11 || rdata !== 32'h0) begin
         n_errors++;
         $display("FAIL collide_old: got bvalid=%b rvalid=%b rdata=%h required 1/1/00000000", bvalid, rvalid, rdata);
      end
      bready = 1'b1; rready = 1'b1; tick(); bready = 1'b0; rready = 1'b0;
      void'(model_write(32'h040, 32'h5, 4'hF));
      axi_read(32'h040, 0, d, r, lat1, ok);
      n_checks++;
      if (d !== 32'h5) begin
         n_errors++; $display("FAIL collide_new: got %h required 00000005", d);
      end
   endtask

   task automatic test_reset_mid();
      bit ok, lat1;
      logic [31:0] d;
      logic [1:0]  r;
      wait_idle(ok);
      awaddr = 32'h080; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== '0) begin
         n_errors++;
         $display("FAIL mid_reset_outputs: got aw%b w%b ar%b b%b r%b rdata%h required all 0",
                  awready, wready, arready, bvalid, rvalid, rdata);
      end
      wdata = 32'hBAD0BAD0; wstrb = 4'hF; wvalid = 1'b1;
      tick(); tick();
      wvalid = 1'b0;
      rst_n = 1'b1;
      wait_idle(ok);
      wdata = 32'h7; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      tick(); tick(); tick();
      n_checks++;
      if (bvalid !== 1'b0) begin
         n_errors++; $display("FAIL mid_reset_stale_aw: got bvalid=%b required 0", bvalid);
      end
      awaddr = 32'h080; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      tick();
      n_checks++;
      if ({bvalid, bresp} !== 3'b100) begin
         n_errors++; $display("FAIL mid_reset_bresp: got %b/%b required 1/00", bvalid, bresp);
      end
      bready = 1'b1; tick(); bready = 1'b0;
      void'(model_write(32'h080, 32'h7, 4'hF));
      axi_read(32'h080, 0, d, r, lat1, ok);
      n_checks++;
      if (d !== 32'h7 || r !== 2'b00) begin
         n_errors++; $display("FAIL mid_reset_read: got %h/%b required 00000007/00", d, r);
      end
   endtask

   task automatic test_random();
      bit ok, lat1;
      logic [31:0] addr, data, d;
      logic [3:0]  strb;
      logic [1:0]  r, exp_r;
      for (int i = 0; i < 150; i++) begin
         addr = $urandom_range(0, 1279) * 4 + $urandom_range(0, 3);
         if ($urandom_range(0, 2) != 0) begin
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            axi_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 2), r, ok);
            exp_r = model_write(addr, data, strb);
            n_checks++;
            if (r !== exp_r || ok !== 1'b1) begin
               n_errors++;
               $display("FAIL rand_write[%0d] addr=%h: got bresp=%b ok=%b required %b ok=1", i, addr, r, ok, exp_r);
            end
         end else begin
            axi_read(addr, $urandom_range(0, 2), d, r, lat1, ok);
            n_checks++;
            if (d !== model_rdata(addr) || r !== model_rresp(addr) || lat1 !== 1'b1 || ok !== 1'b1) begin
               n_errors++;
               $display("FAIL rand_read[%0d] addr=%h: got %h/%b lat1=%b ok=%b required %h/%b lat1=1 ok=1",
                        i, addr, d, r, lat1, ok, model_rdata(addr), model_rresp(addr));
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) model_mem[i] = 32'h0;
      test_reset();
      test_same_cycle_write();
      test_w_before_aw();
      test_out_of_range();
      test_backpressure();
      test_collision();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
